// File: rtl/store_merge_unit.sv
// store_merge_unit: read-modify-write engine that merges byte/half/word/dword stores into memory words
module store_merge_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;
    state_t state, state_n;

    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] bin_q, rdata_q, bmask, merged;
    logic [2:0]            cnt;
    logic [OW-1:0]         off_in, off_q;
    logic                  mis_in, full_in, wait_last;

    assign off_in    = addr[OW-1:0];
    assign off_q     = addr_q[OW-1:0];
    assign wait_last = cnt == 3'(READ_LATENCY - 1);
    assign full_in   = (DATA_WIDTH == 32) ? size == 2'b10 : size == 2'b11;
    assign mis_in    = size == 2'b01 ? off_in[0] :
                       size == 2'b10 ? |off_in[1:0] :
                       size == 2'b11 ? (DATA_WIDTH == 32) || |off_in : 1'b0;

    // A full-width store yields an all-ones mask, so the stale captured word drops out entirely
    always_comb begin
        for (int i = 0; i < NB; i++)
            bmask[i*8 +: 8] = {8{(i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q))}};
        merged = (rdata_q & ~bmask) | ((bin_q << {off_q, 3'b000}) & bmask);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n    = state;
        busy       = state != IDLE;
        done       = 1'b0;
        misaligned = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE:  state_n = !start ? IDLE : mis_in ? ERR : full_in ? WRITE : READ;
            READ:  begin mem_rd = 1'b1; state_n = WAIT; end
            WAIT:  state_n = wait_last ? WRITE : WAIT;
            WRITE: begin mem_wr = 1'b1; state_n = DONE; end
            DONE:  begin done = 1'b1; state_n = IDLE; end
            ERR:   begin misaligned = 1'b1; state_n = IDLE; end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr  = (mem_rd || mem_wr) ? {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
    assign mem_wdata = mem_wr ? merged : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            size_q  <= '0;
            addr_q  <= '0;
            bin_q   <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && start) begin
                size_q <= size;
                addr_q <= addr;
                bin_q  <= b_in;
            end
            if (state == WAIT && wait_last) rdata_q <= mem_rdata;
            cnt <= (state == WAIT && !wait_last) ? cnt + 3'd1 : 3'd0;
        end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: scoreboard bench over three configurations (32b/RL1, 32b/RL3, 64b/RL1)
module tb_store_merge_unit;
    localparam logic [3:0] RD = 4'b1000, WR = 4'b0100, DN = 4'b0010, MS = 4'b0001;

    typedef struct {
        int          cyc;
        int          inst;
        logic [3:0]  k;
        logic [31:0] a;
        logic [63:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  st, bz, dn, ms, rd, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] b_in, mem_rdata;
    logic [31:0] ma0, ma1, ma2, wd0, wd1;
    logic [63:0] wd2;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          t0;
    ev_t         q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    store_merge_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .start(st[0]), .size(size), .addr(addr), .b_in(b_in[31:0]),
        .busy(bz[0]), .done(dn[0]), .misaligned(ms[0]), .mem_addr(ma0), .mem_rd(rd[0]),
        .mem_wr(wr[0]), .mem_wdata(wd0), .mem_rdata(mem_rdata[31:0]));
    store_merge_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(3)) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .size(size), .addr(addr), .b_in(b_in[31:0]),
        .busy(bz[1]), .done(dn[1]), .misaligned(ms[1]), .mem_addr(ma1), .mem_rd(rd[1]),
        .mem_wr(wr[1]), .mem_wdata(wd1), .mem_rdata(mem_rdata[31:0]));
    store_merge_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .READ_LATENCY(1)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .size(size), .addr(addr), .b_in(b_in),
        .busy(bz[2]), .done(dn[2]), .misaligned(ms[2]), .mem_addr(ma2), .mem_rd(rd[2]),
        .mem_wr(wr[2]), .mem_wdata(wd2), .mem_rdata(mem_rdata));

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(int c, int i, logic [3:0] k, logic [31:0] a, logic [63:0] d);
        ev_t e;
        e.cyc = c; e.inst = i; e.k = k; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    // Drives a one-cycle start, then scrambles the request inputs to prove they were registered
    task automatic go(int i, logic [1:0] sz, logic [31:0] a, logic [63:0] b);
        st[i] = 1'b1; size = sz; addr = a; b_in = b;
        @(posedge clk); #1;
        st[i] = 1'b0; size = 2'($urandom); addr = $urandom; b_in = {$urandom, $urandom};
    endtask

    task automatic idle(int i);
        int n = 0;
        while (bz[i] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle", bz[i], 0);
        chk("drain", q.size(), 0);
    endtask

    task automatic mon(int i);
        logic [3:0]  k;
        logic [31:0] a;
        logic [63:0] d;
        ev_t         e;
        k = {rd[i], wr[i], dn[i], ms[i]};
        a = i == 0 ? ma0 : i == 1 ? ma1 : ma2;
        d = i == 0 ? {32'h0, wd0} : i == 1 ? {32'h0, wd1} : wd2;
        if (k == 4'b0) begin
            if (a != 0 || d != 0) chk("quiet_bus", {a, d}, 0);
        end else begin
            chk("excl", $onehot(k), 1);
            if (q.size() == 0) chk("unexpected", k, 0);
            else begin
                e = q.pop_front();
                chk("cycle", cyc, e.cyc);
                chk("inst", i, e.inst);
                chk("kind", k, e.k);
                chk("addr", a, e.a);
                chk("wdata", d, e.d);
            end
        end
    endtask

    always @(negedge clk) if (!reset) for (int i = 0; i < 3; i++) mon(i);

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; st = '0; size = '0; addr = '0; b_in = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {bz, dn, ms, rd, wr}, 0);
        chk("rst_addr", {ma0, ma1, ma2}, 0);
        chk("rst_wdata", {wd0, wd1, wd2}, 0);

        // start accepted on the first edge after reset release
        mem_rdata = 64'h11223344;
        reset = 1'b0;
        t0 = cyc;
        push(t0 + 1, 0, RD, 32'h1000, 0);
        push(t0 + 3, 0, WR, 32'h1000, 64'hAB223344);
        push(t0 + 4, 0, DN, 0, 0);
        go(0, 2'b00, 32'h1003, 64'hAB);
        chk("busy", bz[0], 1);
        idle(0);

        t0 = cyc;
        push(t0 + 1, 0, RD, 32'h2000, 0);
        push(t0 + 3, 0, WR, 32'h2000, 64'hBEEF3344);
        push(t0 + 4, 0, DN, 0, 0);
        go(0, 2'b01, 32'h2002, 64'hFFFFBEEF);
        idle(0);

        t0 = cyc;
        push(t0 + 1, 0, WR, 32'h2000, 64'hCAFEF00D);
        push(t0 + 2, 0, DN, 0, 0);
        go(0, 2'b10, 32'h2000, 64'hCAFEF00D);
        idle(0);

        t0 = cyc;
        push(t0 + 1, 0, RD, 32'h1000, 0);
        push(t0 + 3, 0, WR, 32'h1000, 64'h11223355);
        push(t0 + 4, 0, DN, 0, 0);
        go(0, 2'b00, 32'h1000, 64'h55);
        idle(0);

        t0 = cyc;
        push(t0 + 1, 0, MS, 0, 0);
        go(0, 2'b01, 32'h3001, 64'h1);
        chk("err_busy", bz[0], 1);
        @(posedge clk); #1;
        chk("err_idle", bz[0], 0);
        chk("drain", q.size(), 0);

        t0 = cyc;
        push(t0 + 1, 0, MS, 0, 0);
        go(0, 2'b11, 32'h3000, 64'h1);
        idle(0);

        t0 = cyc;
        push(t0 + 1, 0, MS, 0, 0);
        go(0, 2'b10, 32'h3002, 64'h1);
        idle(0);

        // READ_LATENCY=3: only the cycle-4 read data may land, starts while busy are dropped
        t0 = cyc;
        push(t0 + 1, 1, RD, 32'h5000, 0);
        push(t0 + 5, 1, WR, 32'h5000, 64'hA1B277D4);
        push(t0 + 6, 1, DN, 0, 0);
        mem_rdata = 64'hDEADDEAD;
        go(1, 2'b00, 32'h5001, 64'h77);
        for (int k = 1; k <= 5; k++) begin
            st[1] = 1'b1;
            mem_rdata = (k == 4) ? 64'hA1B2C3D4 : 64'hDEADDEAD;
            @(posedge clk); #1;
        end
        st[1] = 1'b0;
        idle(1);

        mem_rdata = 64'h0;
        t0 = cyc;
        push(t0 + 1, 2, RD, 32'h4000, 0);
        push(t0 + 3, 2, WR, 32'h4000, 64'h1234000000000000);
        push(t0 + 4, 2, DN, 0, 0);
        go(2, 2'b01, 32'h4006, 64'h1234);
        idle(2);

        mem_rdata = 64'h1122334455667788;
        t0 = cyc;
        push(t0 + 1, 2, RD, 32'h10, 0);
        push(t0 + 3, 2, WR, 32'h10, 64'hDEADBEEF55667788);
        push(t0 + 4, 2, DN, 0, 0);
        go(2, 2'b10, 32'h14, 64'hDEADBEEF);
        idle(2);

        t0 = cyc;
        push(t0 + 1, 2, WR, 32'h20, 64'h0123456789ABCDEF);
        push(t0 + 2, 2, DN, 0, 0);
        go(2, 2'b11, 32'h20, 64'h0123456789ABCDEF);
        idle(2);

        t0 = cyc;
        push(t0 + 1, 2, MS, 0, 0);
        go(2, 2'b11, 32'h24, 64'h1);
        idle(2);

        t0 = cyc;
        push(t0 + 1, 2, MS, 0, 0);
        go(2, 2'b10, 32'h22, 64'h1);
        idle(2);

        // reset in WAIT aborts the store: no write may follow
        mem_rdata = 64'h0;
        t0 = cyc;
        push(t0 + 1, 2, RD, 32'h4000, 0);
        go(2, 2'b01, 32'h4006, 64'h1234);
        @(posedge clk); #1;
        chk("wait_busy", bz[2], 1);
        reset = 1'b1;
        #1;
        chk("abort_ctl", {bz[2], rd[2], wr[2], dn[2], ms[2]}, 0);
        chk("abort_bus", {ma2, wd2}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_drain", q.size(), 0);
        chk("abort_idle", bz[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
